// File: rtl/mac_requant_pkg.sv
// Shared quantization helpers: accumulator width, saturation limits and the
// round-half-up arithmetic shift used by requantizing blocks.
package mac_requant_pkg;

    localparam int N_DEF = 18;
    localparam int RS_W  = 64;

    function automatic int acc_w(input int n);
        return 2 * n;
    endfunction

    localparam int ACC_W = acc_w(N_DEF);

    function automatic logic signed [RS_W-1:0] qmax(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [RS_W-1:0] qmin(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    // Callers sign-extend into RS_W so the rounding bias can never wrap.
    function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] a,
                                                            input int s);
        logic signed [RS_W-1:0] bias;
        bias = (s == 0) ? '0 : (64'sd1 <<< (s - 1));
        return (a + bias) >>> s;
    endfunction

endpackage

// File: rtl/mac_rq_stage.sv
// Generic valid/ready pipeline register; loads when empty or when its
// current contents leave in the same cycle.
module mac_rq_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Requantizer: round/shift the 2N-bit accumulator, saturate to N bits,
// optional ReLU, two-stage valid/ready pipeline with a saturation counter.
module mac_requant
    import mac_requant_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int SHW  = 6,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [2*N-1:0] acc_data,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [SHW-1:0]        shift,
    input  logic                  relu_en,
    output logic signed [N-1:0]   q_data,
    output logic                  q_sat,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic [CNTW-1:0]       sat_cnt,
    input  logic                  cnt_clr
);

    localparam int AW = acc_w(N);
    localparam int RW = AW + 1;
    localparam logic signed [RS_W-1:0] QMAX_W = qmax(N);
    localparam logic signed [RS_W-1:0] QMIN_W = qmin(N);
    localparam logic [SHW-1:0]         S_LIM  = SHW'(AW - 1);

    logic [SHW-1:0]         s_eff;
    logic signed [RS_W-1:0] acc_x;
    logic signed [RS_W-1:0] r_full;
    logic signed [RW-1:0]   r_in;
    logic [RW:0]            s1_in;
    logic [RW:0]            s1_out;
    logic                   s1_valid;
    logic                   s2_ready;
    logic signed [RW-1:0]   r1;
    logic                   relu1;
    logic signed [RS_W-1:0] r1_x;
    logic signed [N-1:0]    q_pre;
    logic signed [N-1:0]    q_next;
    logic                   sat_next;
    logic [N:0]             s2_in;
    logic [N:0]             s2_out;
    logic                   unused_hi;

    always_comb begin
        s_eff  = (shift > S_LIM) ? S_LIM : shift;
        acc_x  = {{(RS_W-AW){acc_data[AW-1]}}, acc_data};
        r_full = round_shift(acc_x, int'(s_eff));
        r_in   = r_full[RW-1:0];
        s1_in  = {r_in, relu_en};
    end

    // Rounded value never exceeds RW bits, the upper bits are pure sign.
    assign unused_hi = ^r_full[RS_W-1:RW];

    mac_rq_stage #(.W(RW + 1)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s1_in),
        .in_valid  (acc_valid),
        .in_ready  (acc_ready),
        .out_data  (s1_out),
        .out_valid (s1_valid),
        .out_ready (s2_ready)
    );

    always_comb begin
        r1       = s1_out[RW:1];
        relu1    = s1_out[0];
        r1_x     = {{(RS_W-RW){r1[RW-1]}}, r1};
        sat_next = 1'b1;
        if (r1_x > QMAX_W)
            q_pre = QMAX_W[N-1:0];
        else if (r1_x < QMIN_W)
            q_pre = QMIN_W[N-1:0];
        else begin
            q_pre    = r1[N-1:0];
            sat_next = 1'b0;
        end
        q_next = (relu1 && q_pre[N-1]) ? '0 : q_pre;
        s2_in  = {q_next, sat_next};
    end

    mac_rq_stage #(.W(N + 1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s2_in),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .out_data  (s2_out),
        .out_valid (q_valid),
        .out_ready (q_ready)
    );

    assign q_data = s2_out[N:1];
    assign q_sat  = s2_out[0];

    // Clear wins over a same-cycle saturated transfer; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_cnt <= '0;
        else if (cnt_clr)
            sat_cnt <= '0;
        else if (q_valid && q_ready && q_sat && (sat_cnt != '1))
            sat_cnt <= sat_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_mac_requant.sv
// Bench for mac_requant: directed steps plus random traffic, scored against
// an arithmetic reference model and a queue of expected results.
module tb_mac_requant;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [35:0]  acc_data = '0;
    logic                acc_valid = 1'b0;
    logic                acc_ready;
    logic [5:0]          shift = '0;
    logic                relu_en = 1'b0;
    logic signed [17:0]  q_data;
    logic                q_sat;
    logic                q_valid;
    logic                q_ready = 1'b1;
    logic [15:0]         sat_cnt;
    logic                cnt_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint q;
        logic   sat;
    } exp_t;

    exp_t               expq[$];
    logic [15:0]        exp_cnt = '0;
    logic               prev_hold = 1'b0;
    logic signed [17:0] prev_data = '0;
    logic               prev_sat = 1'b0;

    mac_requant dut (
        .clk       (clk),
        .rst       (rst),
        .acc_data  (acc_data),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .shift     (shift),
        .relu_en   (relu_en),
        .q_data    (q_data),
        .q_sat     (q_sat),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .sat_cnt   (sat_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: floor((acc + half) / 2^s), then clip, then ReLU.
    function automatic exp_t model(input longint a, input int sh, input logic rl);
        exp_t   e;
        longint s, d, sum, r;
        s   = (sh > 35) ? 35 : sh;
        d   = longint'(1) << s;
        sum = a + ((s > 0) ? d / 2 : 0);
        r   = sum / d;
        if ((sum % d) != 0 && sum < 0)
            r = r - 1;
        e.sat = 1'b0;
        if (r > 131071) begin
            r = 131071;
            e.sat = 1'b1;
        end else if (r < -131072) begin
            r = -131072;
            e.sat = 1'b1;
        end
        if (rl && r < 0)
            r = 0;
        e.q = r;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic sat_now;
        if (!rst) begin
            expq.delete();
            exp_cnt   = '0;
            prev_hold = 1'b0;
        end else begin
            sat_now = 1'b0;
            chk("mon_cnt", sat_cnt, exp_cnt);
            if (prev_hold) begin
                chk("hold_vld", q_valid, 1);
                chk("hold_data", q_data, prev_data);
                chk("hold_sat", q_sat, prev_sat);
            end
            if (q_valid && q_ready) begin
                chk("mon_nonempty", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("mon_data", q_data, e.q);
                    chk("mon_sat", q_sat, e.sat);
                    sat_now = e.sat;
                end
            end
            if (cnt_clr)
                exp_cnt = '0;
            else if (sat_now && exp_cnt != 16'hffff)
                exp_cnt = exp_cnt + 16'd1;
            if (acc_valid && acc_ready)
                expq.push_back(model(longint'(acc_data), int'(shift), relu_en));
            prev_hold = q_valid && !q_ready;
            prev_data = q_data;
            prev_sat  = q_sat;
        end
    end

    // One beat into an idle pipeline; config is scrambled right after acceptance.
    task automatic beat(input logic signed [35:0] a, input logic [5:0] sh, input logic rl,
                        input longint ed, input logic es, input string tag);
        @(posedge clk); #1;
        acc_data = a; shift = sh; relu_en = rl; acc_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, acc_ready, 1);
        @(posedge clk); #1;
        acc_valid = 1'b0; shift = ~sh; relu_en = ~rl; acc_data = ~a;
        @(negedge clk);
        chk({tag, "_lat1"}, q_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, q_valid, 1);
        chk({tag, "_data"}, q_data, ed);
        chk({tag, "_sat"}, q_sat, es);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, n;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_qvalid", q_valid, 0);
        chk("rst_qdata", q_data, 0);
        chk("rst_qsat", q_sat, 0);
        chk("rst_cnt", sat_cnt, 0);
        chk("rst_accrdy", acc_ready, 1);
        @(posedge clk); #1; rst = 1'b1;

        // rounding
        beat(36'sd1000, 6'd4, 1'b0, 63, 1'b0, "rnd_1000");
        beat(-36'sd24,  6'd4, 1'b0, -1, 1'b0, "rnd_m24");
        beat(-36'sd8,   6'd4, 1'b0, 0,  1'b0, "rnd_m8");

        // saturation and counter
        beat(36'sd1048576, 6'd0, 1'b0, 131071, 1'b1, "sat_pos");
        @(negedge clk); chk("sat_cnt1", sat_cnt, 1);
        beat(-36'sd1048576, 6'd0, 1'b0, -131072, 1'b1, "sat_neg");
        @(negedge clk); chk("sat_cnt2", sat_cnt, 2);

        // ReLU
        beat(-36'sd1048576, 6'd0, 1'b1, 0, 1'b1, "relu_sat");
        beat(-36'sd5,       6'd0, 1'b1, 0, 1'b0, "relu_m5");
        beat(36'sd500,      6'd0, 1'b1, 500, 1'b0, "relu_500");

        // backpressure: 1..6 with q_ready low for the first 5 cycles
        sent = 0; got = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            acc_valid = (sent < 6); acc_data = 36'(sent + 1); shift = 6'd0; relu_en = 1'b0;
            q_ready = (c >= 5);
            @(negedge clk);
            if (c == 4) begin
                chk("bp_accepted", sent, 2);
                chk("bp_accrdy", acc_ready, 0);
            end
            if (got > 0 && got < 6)
                chk("bp_nogap", q_valid, 1);
            if (q_valid && q_ready) begin
                chk("bp_order", q_data, got + 1);
                got++;
            end
            if (acc_valid && acc_ready)
                sent++;
            @(posedge clk); #1;
        end
        acc_valid = 1'b0; q_ready = 1'b1;
        chk("bp_count", got, 6);

        // shift clamp and extremes
        beat(36'sh800000000, 6'd63, 1'b0, -1, 1'b0, "clamp_min");
        beat(36'sh7ffffffff, 6'd35, 1'b0, 1,  1'b0, "shift35_max");

        // random traffic with random backpressure and clears
        for (int c = 0; c < 400; c++) begin
            logic [63:0] rnd;
            @(posedge clk); #1;
            rnd       = {$urandom, $urandom};
            acc_data  = $signed(rnd[35:0]) >>> $urandom_range(0, 30);
            shift     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 20));
            relu_en   = 1'($urandom_range(0, 1));
            acc_valid = ($urandom_range(0, 3) != 0);
            q_ready   = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1;
        acc_valid = 1'b0; q_ready = 1'b1; cnt_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("rand_drained", expq.size(), 0);

        // reset with two beats in flight
        @(posedge clk); #1;
        acc_data = 36'sd1048576; shift = 6'd0; relu_en = 1'b0; acc_valid = 1'b1;
        @(posedge clk); #1;
        acc_data = 36'sd77;
        @(posedge clk); #1;
        acc_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_qvalid", q_valid, 0);
        chk("mid_rst_cnt", sat_cnt, 0);
        chk("mid_rst_accrdy", acc_ready, 1);
        @(posedge clk); #1; rst = 1'b1;
        beat(36'sd320, 6'd5, 1'b0, 10, 1'b0, "post_rst");

        // counter hold at all-ones
        n = 0;
        @(posedge clk); #1;
        acc_data = 36'sd1048576; shift = 6'd0; relu_en = 1'b0; acc_valid = 1'b1;
        for (int c = 0; c < 70000 && n < 65535; c++) begin
            @(negedge clk);
            if (acc_ready) n++;
            @(posedge clk); #1;
        end
        acc_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_full", sat_cnt, 65535);
        beat(36'sd1048576, 6'd0, 1'b0, 131071, 1'b1, "cnt_extra");
        @(negedge clk); chk("cnt_hold", sat_cnt, 65535);

        // clear coinciding with a saturated transfer
        @(posedge clk); #1;
        acc_data = -36'sd1048576; shift = 6'd0; relu_en = 1'b0; acc_valid = 1'b1;
        @(posedge clk); #1;
        acc_valid = 1'b0;
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_qvalid", q_valid, 1);
        chk("clr_qsat", q_sat, 1);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt", sat_cnt, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
